uart_rx: RTL and testbench
==========================

# uart_rx

8x-oversampling UART receiver: 8 data bits, no parity, 1 stop bit, LSB first. It recovers bytes from the serial `rx` line and presents each one with a one-cycle `received` strobe. It is the receive end of the 8N1 protocol our `uart` transmit path produces, and is intended for the wishbone master handler's host link. A glitch-filtered start detector and 3-sample majority voting make it tolerant of line noise and moderate baud mismatch.

## Interface
- `CLOCK_RATE`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `PRESCALER`, default 8: oversampling ticks per bit. Fixed at 8; other values are unsupported.
- Derived localparam `CLOCK_DIVIDE` = `CLOCK_RATE / (BAUD_RATE * PRESCALER)`, integer division. Elaboration fails if it is less than 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, asynchronous to `clk`; idles high.
- `rx_byte` out 8: last correctly framed byte; held until the next good frame.
- `received` out 1: one-cycle pulse when `rx_byte` updates.
- `is_receiving` out 1: high while a frame is in progress.
- `rx_error` out 1: one-cycle pulse on a framing error.

## Operation
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. `rxs` is the synchronizer output; `rxs_d` is `rxs` delayed one cycle.
- Tick generator: a divider counts 0..`CLOCK_DIVIDE`-1 and emits `tick` on the terminal count. It restarts from 0 at start detection.
- `k` is the tick index since start detection (tick 1 is the first tick). Bit `b` spans ticks 8b..8b+7:
  - b=0 is the start bit.
  - b=1..8 are data bits D0..D7.
  - b=9 is the stop bit.
- For each bit, `rxs` is sampled on ticks 8b+3, 8b+4 and 8b+5. The bit value is the majority of those three samples, decided on tick 8b+5.
- States:
  - IDLE: on `rxs_d`=1 and `rxs`=0 (start detect), clear the divider and `k`, then go to START.
  - START: on tick 5, majority 1 means a false start: go to IDLE with no pulse. Majority 0 continues. On tick 7, go to DATA.
  - DATA: on tick 8b+5, shift the bit into the MSB of the shift register (so the register is LSB-first). After bit 8 completes (tick 71), go to STOP.
  - STOP: on tick 77:
    - majority 1: load `rx_byte` from the shift register and pulse `received`.
    - majority 0: pulse `rx_error`; `rx_byte` is unchanged.
    - In both cases go to IDLE immediately, without waiting for the end of the stop bit. This gives re-sync margin for the next start edge.
- A framing error caused by a low line (break) does not retrigger. A new start requires `rxs` to return to 1 first, which edge detection guarantees.
- `is_receiving` is 1 in START, DATA and STOP.
- There is no overrun flag: a new good frame overwrites `rx_byte`, and the consumer must read it within one frame time.

## Timing
- Reset values: `rx_byte`=0x00, `received`=0, `rx_error`=0, `is_receiving`=0, state IDLE, synchronizer=1. Reset asserted mid-frame aborts it with no pulse.
- Start detection occurs 3 clk after an `rx` falling edge: 2 synchronizer cycles plus 1 edge-detect cycle.
- Tick k occurs `k*CLOCK_DIVIDE` clk after the detection cycle.
- `received`, `rx_error` and `rx_byte` update in the clk after tick 77, and `is_receiving` falls in the same clk.
- `received` and `rx_error` are never high together, and each is exactly 1 clk wide.
- Back-to-back frames: a start edge arriving any time after tick 77 is accepted.

## Structure
- `CLOCK_RATE` comes from `project_defines.v`.
- State encodings (IDLE/START/DATA/STOP) and `PRESCALER`-derived sample positions (3, 4, 5, 7) are localparams in a shared `uart_defines.v`, which the transmit path reuses.
- Sub-module `uart_baud_tick`:
  - inputs `clk`, `rst`, `restart`; output `tick`;
  - parameter `CLOCK_DIVIDE`;
  - shared with the transmitter.
- The rest (synchronizer, FSM, bit and tick counters, shift register) lives in `uart_rx`.

## Test plan
All scenarios use `CLOCK_RATE`=307200, `BAUD_RATE`=9600, so `CLOCK_DIVIDE`=4 and one bit = 32 clk.
- Drive 0xAA LSB-first with 1 stop bit -> one `received` pulse, `rx_byte`=0xAA, `rx_error` stays 0, `is_receiving` high about 310 clk.
- Drive 0x55 then 0x0F back-to-back with no idle -> two `received` pulses with `rx_byte` 0x55 then 0x0F.
- Pull `rx` low for 8 clk (glitch), then hold high -> `is_receiving` pulses briefly, no `received`, no `rx_error`.
- Drive 0xC3 with stop bit = 0 -> `rx_error` pulse, `rx_byte` keeps its previous value, no new start until `rx` returns high.
- Invert `rx` for 4 clk centred on sample tick 8b+4 of D2 while sending 0x00 -> `rx_byte`=0x00 (majority rejects the flip).
- Assert `rst` during D4 of a frame, release, then send 0x81 -> outputs return to their reset values immediately, then `rx_byte`=0x81.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the 8N1 UART receive path: FSM state
//               encoding, oversampling sample positions, tick-index landmarks
//               of a frame and the 3-sample majority helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // Oversampling factor the sample positions below are laid out for.
  localparam int C_PRESCALER = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Sample positions inside one bit (tick index modulo 8).
  localparam logic [2:0] C_SAMPLE_A = 3'd3;
  localparam logic [2:0] C_SAMPLE_B = 3'd4;
  localparam logic [2:0] C_SAMPLE_C = 3'd5;  // majority decided here
  localparam logic [2:0] C_BIT_LAST = 3'd7;

  // Tick indices (since start detection) where the FSM acts.
  localparam logic [6:0] C_TICK_START_VOTE = {4'd0, C_SAMPLE_C};  // 5
  localparam logic [6:0] C_TICK_START_END  = {4'd0, C_BIT_LAST};  // 7
  localparam logic [6:0] C_TICK_DATA_END   = {4'd8, C_BIT_LAST};  // 71
  localparam logic [6:0] C_TICK_STOP_VOTE  = {4'd9, C_SAMPLE_C};  // 77

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Oversampling tick generator. Counts 0..CLOCK_DIVIDE-1 and
//               asserts tick during the terminal count. restart forces the
//               count back to 0 so ticks align to an external event.
// Ports       : clk     - system clock
//               rst     - asynchronous active-low reset
//               restart - clear the divider (next tick CLOCK_DIVIDE clk later)
//               tick    - one-cycle oversampling tick
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int CLOCK_DIVIDE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int              C_CW       = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [C_CW-1:0] C_TERMINAL = C_CW'(CLOCK_DIVIDE - 1);

  logic [C_CW-1:0] r_count;
  logic            w_terminal;

  assign w_terminal = (r_count == C_TERMINAL);
  assign tick       = w_terminal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (restart || w_terminal) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8x-oversampling 8N1 UART receiver, LSB first. Glitch-filtered
//               start detection and 3-sample majority voting per bit.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-low reset
//               rx           - serial input (asynchronous, idles high)
//               rx_byte      - last correctly framed byte
//               received     - one-cycle pulse when rx_byte updates
//               is_receiving - high while a frame is in progress
//               rx_error     - one-cycle pulse on a framing error
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PRESCALER  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       received,
  output logic       is_receiving,
  output logic       rx_error
);

  localparam int CLOCK_DIVIDE = CLOCK_RATE / (BAUD_RATE * PRESCALER);

  if (CLOCK_DIVIDE < 2) begin : g_divide_check
    $error("uart_rx: CLOCK_DIVIDE must be at least 2");
  end

  if (PRESCALER != C_PRESCALER) begin : g_prescaler_check
    $error("uart_rx: only PRESCALER = 8 is supported");
  end

  rx_state_t  r_state, w_next_state;
  logic       r_rx_meta, r_rxs, r_rxs_d;
  logic [6:0] r_tick_cnt;
  logic       r_samp_a, r_samp_b;
  logic [7:0] r_shift;
  logic [7:0] r_rx_byte;
  logic       r_received, r_rx_error;

  logic       w_tick;
  logic       w_start_det;
  logic [6:0] w_k;
  logic [2:0] w_phase;
  logic       w_bit_val;
  logic       w_shift_en, w_frame_ok, w_frame_err;

  // Only a falling edge seen while idle starts a frame; a line held low after
  // a framing error never produces the 1->0 pattern until it returns high.
  assign w_start_det = (r_state == ST_IDLE) && r_rxs_d && !r_rxs;
  assign w_k         = r_tick_cnt + 7'd1;   // index of the tick now occurring
  assign w_phase     = w_k[2:0];
  assign w_bit_val   = majority3(r_samp_a, r_samp_b, r_rxs);

  uart_baud_tick #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(w_start_det),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_frame_ok   = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_det) w_next_state = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          if (w_k == C_TICK_START_VOTE && w_bit_val) begin
            w_next_state = ST_IDLE;           // false start: glitch rejected
          end else if (w_k == C_TICK_START_END) begin
            w_next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (w_phase == C_SAMPLE_C) w_shift_en = 1'b1;
          if (w_k == C_TICK_DATA_END) w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        // Decide mid stop bit and return to idle at once for re-sync margin.
        if (w_tick && w_k == C_TICK_STOP_VOTE) begin
          w_next_state = ST_IDLE;
          if (w_bit_val) w_frame_ok  = 1'b1;
          else           w_frame_err = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_samp_a   <= 1'b1;
      r_samp_b   <= 1'b1;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_received <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      if (w_start_det) begin
        r_tick_cnt <= '0;
      end else if (w_tick && r_state != ST_IDLE) begin
        r_tick_cnt <= w_k;
      end

      if (w_tick && w_phase == C_SAMPLE_A) r_samp_a <= r_rxs;
      if (w_tick && w_phase == C_SAMPLE_B) r_samp_b <= r_rxs;

      // LSB arrives first, so shifting in at the MSB leaves D0 in bit 0.
      if (w_shift_en) r_shift <= {w_bit_val, r_shift[7:1]};

      if (w_frame_ok) r_rx_byte <= r_shift;
      r_received <= w_frame_ok;
      r_rx_error <= w_frame_err;
    end
  end

  assign rx_byte      = r_rx_byte;
  assign received     = r_received;
  assign rx_error     = r_rx_error;
  assign is_receiving = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 32 clk per bit. Frames are
//               driven clk by clk; a queue of expected outcomes (good byte or
//               framing error) is matched against received/rx_error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int C_BIT_CLK   = 32;
  localparam int C_FRAME_CLK = 10 * C_BIT_CLK;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       received, is_receiving, rx_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outcome per frame: {is_error, data}.
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         busy_run  = 0;
  int         last_run  = 0;
  logic       prev_pulse = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCK_RATE(307200),
    .BAUD_RATE (9600),
    .PRESCALER (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_byte     (rx_byte),
    .received    (received),
    .is_receiving(is_receiving),
    .rx_error    (rx_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse scoreboard and busy-duration monitor.
  always @(negedge clk) begin
    logic [8:0] e;
    if (prev_pulse) check("pulse_width", {30'd0, received, rx_error}, 32'd0);
    prev_pulse = received | rx_error;
    if (received || rx_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, received, rx_error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, received, rx_error}, e[8] ? 32'd1 : 32'd2);
        if (!e[8]) begin
          check("rx_byte", {24'd0, rx_byte}, {24'd0, e[7:0]});
          last_good = e[7:0];
        end else begin
          check("rx_byte_held", {24'd0, rx_byte}, {24'd0, last_good});
        end
      end
    end
    if (is_receiving) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; bits inside [g_lo,g_hi] (clk index from the start edge)
  // are inverted. rst_at >= 0 pulls reset at that clk index and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int g_lo, input int g_hi, input int rst_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < C_FRAME_CLK; i++) begin
      if (rst_at >= 0 && i >= rst_at) rx = 1'b1;
      else rx = bits[i / C_BIT_CLK] ^ (i >= g_lo && i <= g_hi);
      if (i == rst_at) begin
        rst = 1'b0;
        last_good = 8'h00;
        #1;
        check("midrst_byte",  {24'd0, rx_byte}, 32'h00);
        check("midrst_busy",  {31'd0, is_receiving}, 32'd0);
        check("midrst_recv",  {31'd0, received}, 32'd0);
        check("midrst_err",   {31'd0, rx_error}, 32'd0);
      end
      if (rst_at >= 0 && i == rst_at + 4) rst = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    int         c, any_busy;

    repeat (4) @(negedge clk);
    check("rst_byte", {24'd0, rx_byte}, 32'h00);
    check("rst_recv", {31'd0, received}, 32'd0);
    check("rst_busy", {31'd0, is_receiving}, 32'd0);
    check("rst_err",  {31'd0, rx_error}, 32'd0);
    rst = 1'b1;
    idle(16);

    // Single frame and its busy duration (tick 77 at 4 clk/tick).
    exp_q.push_back({1'b0, 8'hAA});
    send_frame(8'hAA, 1'b1, -10, -10, -1);
    idle(16);
    check("busy_len_aa", last_run, 308);

    // Back-to-back frames, no idle between.
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'h0F});
    send_frame(8'h55, 1'b1, -10, -10, -1);
    send_frame(8'h0F, 1'b1, -10, -10, -1);
    idle(16);

    // 8-clk glitch: false start rejected at tick 5.
    rx = 1'b0;
    repeat (8) @(negedge clk);
    idle(60);
    check("glitch_busy_len", last_run, 20);

    // Stop bit low, line then held low (break): error, no retrigger.
    exp_q.push_back({1'b1, 8'hC3});
    send_frame(8'hC3, 1'b0, -10, -10, -1);
    check("err_busy_len", last_run, 308);
    any_busy = 0;
    rx = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (is_receiving) any_busy = 1;
    end
    check("break_no_restart", any_busy, 0);
    idle(32);

    // 0x00 with a 4-clk flip on the middle sample of D2.
    exp_q.push_back({1'b0, 8'h00});
    send_frame(8'h00, 1'b1, 110, 113, -1);
    idle(16);

    // Random frames, random stop bit, one flipped sample on a random data bit.
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      c    = 4 * (8 * $urandom_range(1, 8) + $urandom_range(3, 5));
      exp_q.push_back({~stop, d});
      send_frame(d, stop, c - 2, c + 1, -1);
      idle($urandom_range(0, 20));
    end

    // Known byte, then reset during D4 of the next frame, then 0x81.
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, -10, -10, -1);
    idle(16);
    send_frame(8'hFF, 1'b1, -10, -10, 5 * C_BIT_CLK + 10);
    idle(16);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, -10, -10, -1);
    idle(16);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    check("final_byte", {24'd0, rx_byte}, 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
